mod_exp_ctrl: RTL and testbench
===============================

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset, sampled on the rising edge of pclk.
REQ-002 SHALL provide these ports:
- pclk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin an exponentiation; sampled only in IDLE.
- base_m  in  64  base in Montgomery form (base*2^64 mod M); latched at start.
- one_m  in  64  2^64 mod M; latched at start.
- exponent  in  64  exponent; latched at start.
- modulus  in  64  odd modulus M; latched at start.
- mm_go  out  1  GO to the Montgomery multiplier; held high for a whole operation.
- mm_a  out  64  multiplier operand A.
- mm_b  out  64  multiplier operand B.
- mm_m  out  64  multiplier modulus (latched modulus).
- mm_p  in  64  multiplier product.
- mm_ready  in  1  multiplier is_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  64  base^exponent mod M in normal (non-Montgomery) form; held until the next accepted start.

Function
REQ-003 SHALL implement left-to-right square-and-multiply on an accumulator X, with states IDLE, SCAN, ISSUE, RUN and FINISH.
REQ-004 IDLE: start=1 SHALL latch all four inputs, clear the bit index to 63, set X=one_m, assert busy and go to SCAN. start SHALL be ignored in every other state.
REQ-005 SCAN (leading-zero skip): while exponent[idx]=0 and idx>0, idx SHALL decrement by one per cycle with no multiplier operation.
REQ-006 First set bit found at idx=k: X SHALL load base_m directly, with no multiply. The remaining bits k-1..0 are then processed.
REQ-007 SCAN reaching idx=0 with exponent[0]=0: X SHALL remain one_m.
REQ-008 For each remaining bit i from k-1 down to 0, the block SHALL perform a square (A=X, B=X). If exponent[i]=1, it SHALL then perform a multiply (A=X, B=base_m).
REQ-009 After all bits are processed, the block SHALL perform one conversion (A=X, B=64'h1) to leave Montgomery form.
REQ-010 Each operation SHALL take one ISSUE cycle (mm_go=0, mm_a/mm_b updated) followed by RUN cycles (mm_go=1, operands stable).
REQ-011 In RUN, on the first cycle with mm_ready=1, the block SHALL capture mm_p into X and move to the next ISSUE or to FINISH. mm_go SHALL therefore be low for at least one cycle between operations.
REQ-012 mm_a, mm_b and mm_m SHALL NOT change while mm_go=1.
REQ-013 mm_ready SHALL be ignored when mm_go=0.
REQ-014 Operation count SHALL be exactly k + (popcount(exponent)-1) + 1 for exponent≠0, and exactly 1 for exponent=0.
REQ-015 Total latency from start to done SHALL be (cycles spent in SCAN) + sum over all operations of (1 + RUN cycles) + 1.
REQ-016 FINISH: the block SHALL write result=X, pulse done for exactly one cycle, deassert busy in the same cycle and return to IDLE.
REQ-017 A start arriving in the done cycle SHALL be ignored. A start in the following (IDLE) cycle SHALL be accepted.
REQ-018 There is no timeout: RUN SHALL wait indefinitely for mm_ready.
REQ-019 The bit index SHALL be 6 bits wide and SHALL never wrap below 0.

Reset
REQ-020 While nreset=0 at a pclk edge, the following SHALL be forced:
- state IDLE, mm_go=0, busy=0, done=0;
- result=0, mm_a=0, mm_b=0, mm_m=0;
- X=0, index=63.
REQ-021 Reset asserted mid-operation SHALL abort that operation. mm_go=0 in the following cycle also resets the multiplier. No done pulse SHALL be produced for the aborted request.

Verification
REQ-022 The bench SHALL cover these directed scenarios, each against a behavioural 65-cycle Montgomery multiplier model (R=2^64):
- Setup for the first three scenarios: M=0xFFFFFFFFFFFFFFC5, base=3, base_m=0xB1, one_m=0x3B.
- exponent=5 with the setup above -> result=0xF3; 4 mm_go rising edges (square, square, multiply, convert); one done pulse.
- exponent=0 with the setup above -> result=0x1; exactly 1 operation; SCAN lasts 64 cycles.
- exponent=1 with the setup above -> result=0x3; exactly 1 operation (conversion only).
- exponent=0xFFFFFFFFFFFFFFFF -> 127 operations; result matches a golden modexp; mm_a/mm_b stable across every mm_go-high window; mm_go low ≥1 cycle between operations.
- nreset low during the 3rd RUN, then start with exponent=5 -> no done from the first request; mm_go=0 the cycle after reset; second request yields result=0xF3.
- start pulsed during busy and in the done cycle -> ignored, result unchanged; start one cycle after done -> accepted.

Source files
------------

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_ctrl
//  Description : Left-to-right square-and-multiply sequencer for 64-bit
//                modular exponentiation. It drives an external Montgomery
//                multiplier (R = 2^64) and returns base^exponent mod M in
//                normal form.
//
//  Ports
//    pclk, nreset          clock, synchronous active-low reset
//    start                 request, sampled only in IDLE
//    base_m, one_m         base*R mod M and R mod M (latched at start)
//    exponent, modulus     exponent and odd modulus M (latched at start)
//    mm_go                 multiplier GO, high for a whole operation
//    mm_a, mm_b, mm_m      multiplier operands, stable while mm_go=1
//    mm_p, mm_ready        multiplier product and ready flag
//    busy, done, result    status, one-cycle completion pulse, result
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        start,
    input  logic [63:0] base_m,
    input  logic [63:0] one_m,
    input  logic [63:0] exponent,
    input  logic [63:0] modulus,
    output logic        mm_go,
    output logic [63:0] mm_a,
    output logic [63:0] mm_b,
    output logic [63:0] mm_m,
    input  logic [63:0] mm_p,
    input  logic        mm_ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ISSUE  = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Kind of the operation pending in ISSUE/RUN.
    typedef enum logic [1:0] {
        OP_SQR  = 2'd0,
        OP_MUL  = 2'd1,
        OP_CONV = 2'd2
    } op_t;

    localparam logic [5:0]  c_IDX_TOP = 6'd63;
    localparam logic [63:0] c_ONE     = 64'h1;

    state_t      r_state, w_state_nxt;
    op_t         r_op,    w_op_nxt;
    logic [5:0]  r_idx,   w_idx_nxt;
    logic [63:0] r_x,     w_x_nxt;
    logic [63:0] r_a,     w_a_nxt;
    logic [63:0] r_b,     w_b_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic [63:0] r_base;
    logic [63:0] r_exp;
    logic [63:0] r_mod;
    logic        w_load;
    logic        w_bit;
    logic        w_last;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_SQR;
            r_idx    <= c_IDX_TOP;
            r_x      <= 64'd0;
            r_a      <= 64'd0;
            r_b      <= 64'd0;
            r_result <= 64'd0;
            r_base   <= 64'd0;
            r_exp    <= 64'd0;
            r_mod    <= 64'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_idx    <= w_idx_nxt;
            r_x      <= w_x_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_result <= w_result_nxt;
            if (w_load) begin
                r_base <= base_m;
                r_exp  <= exponent;
                r_mod  <= modulus;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_idx_nxt    = r_idx;
        w_x_nxt      = r_x;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_result_nxt = r_result;
        w_load       = 1'b0;
        w_bit        = r_exp[r_idx];
        w_last       = (r_idx == 6'd0);

        mm_go  = (r_state == S_RUN);
        busy   = (r_state == S_SCAN) || (r_state == S_ISSUE) || (r_state == S_RUN);
        done   = (r_state == S_FINISH);
        mm_a   = r_a;
        mm_b   = r_b;
        mm_m   = r_mod;
        result = r_result;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = c_IDX_TOP;
                    w_x_nxt     = one_m;
                    w_state_nxt = S_SCAN;
                end
            end

            S_SCAN: begin
                if (w_bit) begin
                    // Leading one: X = base directly, no multiply needed.
                    w_x_nxt     = r_base;
                    w_state_nxt = S_ISSUE;
                    if (w_last) begin
                        w_op_nxt = OP_CONV;
                    end else begin
                        w_op_nxt  = OP_SQR;
                        w_idx_nxt = r_idx - 6'd1;
                    end
                end else if (w_last) begin
                    // Zero exponent: X stays R mod M, only convert.
                    w_op_nxt    = OP_CONV;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_idx_nxt = r_idx - 6'd1;
                end
            end

            S_ISSUE: begin
                w_a_nxt = r_x;
                case (r_op)
                    OP_SQR:  w_b_nxt = r_x;
                    OP_MUL:  w_b_nxt = r_base;
                    default: w_b_nxt = c_ONE;
                endcase
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                if (mm_ready) begin
                    w_x_nxt     = mm_p;
                    w_state_nxt = S_ISSUE;
                    case (r_op)
                        OP_SQR: begin
                            // r_idx is the bit being processed; a set bit
                            // needs the multiply before moving on.
                            if (w_bit) begin
                                w_op_nxt = OP_MUL;
                            end else if (w_last) begin
                                w_op_nxt = OP_CONV;
                            end else begin
                                w_op_nxt  = OP_SQR;
                                w_idx_nxt = r_idx - 6'd1;
                            end
                        end
                        OP_MUL: begin
                            if (w_last) begin
                                w_op_nxt = OP_CONV;
                            end else begin
                                w_op_nxt  = OP_SQR;
                                w_idx_nxt = r_idx - 6'd1;
                            end
                        end
                        default: begin
                            // Conversion product is the final answer; it is
                            // stored now so result is valid in the done cycle.
                            w_result_nxt = mm_p;
                            w_state_nxt  = S_FINISH;
                        end
                    endcase
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_exp_ctrl
//  Description : Self-checking bench for mod_exp_ctrl with a behavioural
//                65-cycle Montgomery multiplier (R = 2^64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_ctrl;

    localparam logic [63:0] c_M     = 64'hFFFFFFFFFFFFFFC5;
    localparam logic [63:0] c_BASEM = 64'hB1;
    localparam logic [63:0] c_ONEM  = 64'h3B;

    logic        pclk;
    logic        nreset;
    logic        start;
    logic [63:0] base_m, one_m, exponent, modulus;
    logic        mm_go;
    logic [63:0] mm_a, mm_b, mm_m, mm_p;
    logic        mm_ready;
    logic        busy, done;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    mod_exp_ctrl dut (
        .pclk     (pclk),
        .nreset   (nreset),
        .start    (start),
        .base_m   (base_m),
        .one_m    (one_m),
        .exponent (exponent),
        .modulus  (modulus),
        .mm_go    (mm_go),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_m     (mm_m),
        .mm_p     (mm_p),
        .mm_ready (mm_ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Bit-serial Montgomery product a*b*2^-64 mod m.
    function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
        logic [65:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[63:0];
    endfunction

    // Golden plain modexp using wide arithmetic.
    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r, bb, mm;
        mm = {64'd0, m};
        bb = {64'd0, b} % mm;
        r  = 128'd1;
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return r[63:0];
    endfunction

    // Multiplier model: ready on the 65th consecutive cycle of mm_go.
    int mcnt;
    always @(posedge pclk) begin
        if (!mm_go) begin
            mcnt     <= 0;
            mm_ready <= 1'b0;
        end else begin
            mcnt     <= mcnt + 1;
            mm_ready <= (mcnt == 63);
        end
    end
    assign mm_p = mm_ready ? mont(mm_a, mm_b, mm_m) : 64'h0;

    // Interface monitor.
    int          go_rises = 0, stab_err = 0, done_cnt = 0, dbl_done = 0;
    logic        p_go = 1'b0, p_done = 1'b0;
    logic [63:0] p_a = '0, p_b = '0, p_m = '0;
    always @(negedge pclk) begin
        if (mm_go && p_go && (mm_a != p_a || mm_b != p_b || mm_m != p_m))
            stab_err <= stab_err + 1;
        if (mm_go && !p_go) go_rises <= go_rises + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && p_done) dbl_done <= dbl_done + 1;
        p_go   <= mm_go;
        p_done <= done;
        p_a    <= mm_a;
        p_b    <= mm_b;
        p_m    <= mm_m;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
        #1;
    endtask

    task automatic drive(input logic [63:0] e, input logic [63:0] b);
        start    = 1'b1;
        exponent = e;
        base_m   = b;
        one_m    = c_ONEM;
        modulus  = c_M;
    endtask

    // Waits for done, clearing start after the first cycle.
    task automatic wait_done(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            cyc();
            start = 1'b0;
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [63:0] e;
        logic [63:0] res;
        int          ops;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  n, g0, d0, s0;
        bit  ok;

        vecs[0] = '{64'd5, 64'hF3, 4, 327};
        vecs[1] = '{64'd0, 64'h1, 1, 131};
        vecs[2] = '{64'd1, 64'h3, 1, 131};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, modexp(64'd3, 64'hFFFFFFFFFFFFFFFF, c_M), 127, 8384};
        vecs[4] = '{64'd6, 64'h2D9, 4, 327};
        vecs[5] = '{64'h8000000000000000, modexp(64'd3, 64'h8000000000000000, c_M), 64, 4226};

        nreset = 1'b0; start = 1'b0;
        exponent = '0; base_m = '0; one_m = '0; modulus = '0;
        repeat (3) cyc();
        chk("rst_go",     64'(mm_go), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_mm_a",   mm_a, 64'd0);
        chk("rst_mm_b",   mm_b, 64'd0);
        chk("rst_mm_m",   mm_m, 64'd0);
        nreset = 1'b1;
        cyc();

        // Table-driven requests.
        for (int v = 0; v < 6; v++) begin
            g0 = go_rises; d0 = done_cnt; s0 = stab_err;
            drive(vecs[v].e, c_BASEM);
            wait_done(20000, n, ok);
            chk($sformatf("v%0d_done_seen", v), 64'(ok), 64'd1);
            chk($sformatf("v%0d_result", v), result, vecs[v].res);
            chk($sformatf("v%0d_latency", v), 64'(n), 64'(vecs[v].lat));
            chk($sformatf("v%0d_ops", v), 64'(go_rises - g0), 64'(vecs[v].ops));
            chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("v%0d_stable", v), 64'(stab_err - s0), 64'd0);
            cyc();
            chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'd0);
        end

        // Reset during the third RUN aborts the request.
        g0 = go_rises; d0 = done_cnt;
        drive(64'd5, c_BASEM);
        n = 0;
        while ((go_rises - g0) < 3 && n < 2000) begin
            cyc();
            start = 1'b0;
            n++;
        end
        chk("abort_reached_run3", 64'(go_rises - g0), 64'd3);
        repeat (10) cyc();
        chk("abort_in_run", 64'(mm_go), 64'd1);
        nreset = 1'b0;
        cyc();
        chk("abort_go_low", 64'(mm_go), 64'd0);
        chk("abort_busy",   64'(busy), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_mm_a",   mm_a, 64'd0);
        nreset = 1'b1;
        repeat (400) cyc();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        drive(64'd5, c_BASEM);
        wait_done(2000, n, ok);
        chk("abort_rerun_done", 64'(ok), 64'd1);
        chk("abort_rerun_res",  result, 64'hF3);
        cyc();

        // Start during busy and in the done cycle is ignored.
        g0 = go_rises; d0 = done_cnt;
        drive(64'd5, c_BASEM);
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        drive(64'd1, 64'h1234);
        cyc();
        start = 1'b0;
        base_m = c_BASEM;
        wait_done(2000, n, ok);
        chk("busy_start_done", 64'(ok), 64'd1);
        chk("busy_start_res",  result, 64'hF3);
        drive(64'd1, c_BASEM);
        cyc();
        chk("donecyc_start_ignored", 64'(busy), 64'd0);
        chk("donecyc_result_held",   result, 64'hF3);
        cyc();
        start = 1'b0;
        chk("after_done_accepted", 64'(busy), 64'd1);
        wait_done(2000, n, ok);
        chk("after_done_done", 64'(ok), 64'd1);
        chk("after_done_res",  result, 64'h3);
        chk("start_ops",  64'(go_rises - g0), 64'd5);
        chk("start_dones", 64'(done_cnt - d0), 64'd2);
        cyc();
        chk("done_single_cycle", 64'(dbl_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
